fp16_accumulator: RTL and testbench

FP16_ACCUMULATOR -- requirements
Module: fp16_accumulator

---
 rtl/fp16_accumulator_pkg.sv | 18 +
 rtl/fp16_accumulator_add.sv | 94 +++++++++
 rtl/fp16_accumulator.sv | 97 +++++++++
 tb/tb_fp16_accumulator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fp16_accumulator_pkg.sv
// Shared definitions for the FP16 accumulator and its adder.
// Contents: FP16 field widths, exponent bias, the reserved all-ones exponent,
// the exception-flag width and the accumulator FSM state encoding.
package fp16_accumulator_pkg;

    localparam int FP_W    = 16;
    localparam int EXP_W   = 5;
    localparam int FRAC_W  = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;
    localparam int FLAG_W  = 5;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/fp16_accumulator_add.sv
// fp16_add: single-cycle combinational FP16 adder, truncating toward zero.
// Ports:
//   a, b  - FP16 operands (denormals are treated as zero)
//   sum   - FP16 result; exact zero and underflow give +0
//   ovf   - result saturated to infinity, or an operand was already inf/NaN
module fp16_add
    import fp16_accumulator_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] sum,
    output logic            ovf
);

    logic [FP_W-2:0]    mag_a, mag_b, big_mag, small_mag;
    logic               big_sign, small_sign;
    logic [FRAC_W:0]    m_big, m_small, aligned, shifted;
    logic [EXP_W-1:0]   e_big, e_small, diff;
    logic [FRAC_W+1:0]  raw;
    logic [3:0]         lead, lz;
    logic signed [6:0]  exp_n;
    logic [FRAC_W-1:0]  frac;

    // Zero exponent flushes the whole operand to zero before ordering, so a
    // denormal can never be picked as the larger operand.
    always_comb begin
        mag_a = (a[FP_W-2:FRAC_W] == '0) ? '0 : a[FP_W-2:0];
        mag_b = (b[FP_W-2:FRAC_W] == '0) ? '0 : b[FP_W-2:0];
        if (mag_a >= mag_b) begin
            big_mag    = mag_a;
            big_sign   = a[FP_W-1];
            small_mag  = mag_b;
            small_sign = b[FP_W-1];
        end else begin
            big_mag    = mag_b;
            big_sign   = b[FP_W-1];
            small_mag  = mag_a;
            small_sign = a[FP_W-1];
        end
        e_big   = big_mag[FP_W-2:FRAC_W];
        e_small = small_mag[FP_W-2:FRAC_W];
        m_big   = (e_big == '0)   ? '0 : {1'b1, big_mag[FRAC_W-1:0]};
        m_small = (e_small == '0) ? '0 : {1'b1, small_mag[FRAC_W-1:0]};
        diff    = e_big - e_small;
        aligned = (diff >= 5'd12) ? '0 : (m_small >> diff);
        if (big_sign == small_sign)
            raw = {1'b0, m_big} + {1'b0, aligned};
        else
            raw = {1'b0, m_big} - {1'b0, aligned};
    end

    // Leading-one detect over the 11-bit mantissa field; a carry into bit 11
    // is handled separately as a one-place right normalisation.
    always_comb begin
        lead = 4'd0;
        for (int i = 0; i <= FRAC_W; i++) begin
            if (raw[i])
                lead = i[3:0];
        end
        lz      = 4'd10 - lead;
        shifted = raw[FRAC_W:0] << lz;
        if (raw[FRAC_W+1]) begin
            exp_n = $signed({2'b00, e_big}) + 7'sd1;
            frac  = raw[FRAC_W:1];
        end else begin
            exp_n = $signed({2'b00, e_big}) - $signed({3'b000, lz});
            frac  = shifted[FRAC_W-1:0];
        end
    end

    // Result selection: an infinite operand dominates, then zero, then
    // exponent overflow/underflow, else the normalised value.
    always_comb begin
        sum = '0;
        ovf = 1'b0;
        if (b[FP_W-2:FRAC_W] == EXP_MAX[EXP_W-1:0]) begin
            sum = {b[FP_W-1], EXP_MAX[EXP_W-1:0], {FRAC_W{1'b0}}};
            ovf = 1'b1;
        end else if (a[FP_W-2:FRAC_W] == EXP_MAX[EXP_W-1:0]) begin
            sum = {a[FP_W-1], EXP_MAX[EXP_W-1:0], {FRAC_W{1'b0}}};
            ovf = 1'b1;
        end else if (raw == '0) begin
            sum = '0;
        end else if (exp_n >= 7'sd31) begin
            sum = {big_sign, EXP_MAX[EXP_W-1:0], {FRAC_W{1'b0}}};
            ovf = 1'b1;
        end else if (exp_n <= 7'sd0) begin
            sum = '0;
        end else begin
            sum = {big_sign, exp_n[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/fp16_accumulator.sv
// fp16_accumulator: sums a stream of FP16 products into one FP16 result per
// vector, with a valid/ready handshake on the result side.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_data    - product word and its presence strobe
//   in_flags            - multiplier exception flags for in_data
//   in_last             - final element of the vector
//   in_ready            - word accepted this cycle (high while accumulating)
//   out_valid/out_ready - result handshake
//   out_data            - FP16 sum, out_flags - OR of input flags
//   out_ovf             - sum saturated to infinity, out_count - element count
module fp16_accumulator
    import fp16_accumulator_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    input  logic [FLAG_W-1:0] in_flags,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [FLAG_W-1:0] out_flags,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_count
);

    fsm_state_t        state;
    logic [DWIDTH-1:0] acc, add_sum, acc_next;
    logic [FLAG_W-1:0] flags, flags_next;
    logic              ovf, add_ovf, ovf_next, accept;
    logic [CNT_W-1:0]  count, count_next;

    fp16_add u_add (
        .a   (acc),
        .b   (in_data),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign in_ready = (state == ACCUM);
    assign accept   = in_ready & in_valid;

    // Once saturated the accumulator stays at its infinity until the vector
    // ends; the counter sticks at all-ones rather than wrapping.
    always_comb begin
        acc_next   = ovf ? acc : add_sum;
        ovf_next   = ovf | add_ovf;
        flags_next = flags | in_flags;
        count_next = (&count) ? count : count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            flags     <= '0;
            ovf       <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else if (state == ACCUM) begin
            if (accept) begin
                acc   <= acc_next;
                flags <= flags_next;
                ovf   <= ovf_next;
                count <= count_next;
                if (in_last) begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                    out_data  <= acc_next;
                    out_flags <= flags_next;
                    out_ovf   <= ovf_next;
                    out_count <= count_next;
                end
            end
        end else begin
            if (out_ready) begin
                state     <= ACCUM;
                out_valid <= 1'b0;
                acc       <= '0;
                flags     <= '0;
                ovf       <= 1'b0;
                count     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fp16_accumulator.sv
// Self-checking bench for fp16_accumulator: table of vectors plus hand-written
// hold, reset and counter-saturation sequences. The counter is narrowed to
// 3 bits so its saturation point is reachable quickly.
module tb_fp16_accumulator;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_last, out_ready;
    logic [15:0]   in_data;
    logic [4:0]    in_flags;
    logic          in_ready, out_valid, out_ovf;
    logic [15:0]   out_data;
    logic [4:0]    out_flags;
    logic [CW-1:0] out_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [15:0]   data;
        logic [4:0]    flags;
        logic          ovf;
        logic [CW-1:0] count;
    } result_t;

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][15:0] words;
        logic [3:0][4:0]  wflags;
        result_t          res;
    } vec_t;

    result_t sb[$];
    vec_t    vecs[13];

    fp16_accumulator #(.DWIDTH(16), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_flags  (in_flags),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mkVec(input logic [2:0] n,
                                   input logic [15:0] w0, input logic [15:0] w1,
                                   input logic [15:0] w2, input logic [15:0] w3,
                                   input logic [4:0] f0, input logic [4:0] f1,
                                   input logic [15:0] ed, input logic [4:0] ef,
                                   input logic eo, input logic [CW-1:0] ec);
        vec_t v;
        v.n          = n;
        v.words      = {w3, w2, w1, w0};
        v.wflags     = {5'd0, 5'd0, f1, f0};
        v.res.data   = ed;
        v.res.flags  = ef;
        v.res.ovf    = eo;
        v.res.count  = ec;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [4:0] f,
                                 input logic last);
        @(negedge clk);
        checkOutput("in_ready_accum", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_flags = f;
        in_last  = last;
    endtask

    // Checks the result exactly one cycle after the last word was accepted.
    task automatic collectOutput();
        result_t r;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_flags = 5'd0;
        checkOutput("latency_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("in_ready_hold", {31'd0, in_ready}, 32'd0);
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            r = sb.pop_front();
            checkOutput("out_data", {16'd0, out_data}, {16'd0, r.data});
            checkOutput("out_flags", {27'd0, out_flags}, {27'd0, r.flags});
            checkOutput("out_ovf", {31'd0, out_ovf}, {31'd0, r.ovf});
            checkOutput("out_count", {29'd0, out_count}, {29'd0, r.count});
        end
    endtask

    task automatic releaseOutput();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("out_valid_cleared", {31'd0, out_valid}, 32'd0);
        checkOutput("in_ready_back", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic runVector(input vec_t v);
        for (int i = 0; i < int'(v.n); i++) begin
            applyStimulus(v.words[i], v.wflags[i], (i == int'(v.n) - 1));
            if (i == int'(v.n) - 1)
                sb.push_back(v.res);
        end
        collectOutput();
    endtask

    initial begin
        vecs[0]  = mkVec(2, 16'h3C00, 16'h4000, 0, 0, 0, 0, 16'h4200, 0, 0, 2);
        vecs[1]  = mkVec(4, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 0, 0, 16'h4400, 0, 0, 4);
        vecs[2]  = mkVec(2, 16'h4000, 16'hC000, 0, 0, 0, 0, 16'h0000, 0, 0, 2);
        vecs[3]  = mkVec(2, 16'h7800, 16'h7800, 0, 0, 0, 0, 16'h7C00, 0, 1, 2);
        vecs[4]  = mkVec(2, 16'h3C00, 16'h3C00, 0, 0, 5'h01, 5'h04, 16'h4000, 5'h05, 0, 2);
        vecs[5]  = mkVec(2, 16'h3C00, 16'hFC00, 0, 0, 0, 0, 16'hFC00, 0, 1, 2);
        vecs[6]  = mkVec(3, 16'h7800, 16'h7800, 16'hC000, 0, 0, 0, 16'h7C00, 0, 1, 3);
        vecs[7]  = mkVec(2, 16'h0001, 16'h3C00, 0, 0, 0, 0, 16'h3C00, 0, 0, 2);
        vecs[8]  = mkVec(2, 16'hBC00, 16'h3800, 0, 0, 0, 0, 16'hB800, 0, 0, 2);
        vecs[9]  = mkVec(2, 16'h3C00, 16'h1400, 0, 0, 0, 0, 16'h3C01, 0, 0, 2);
        vecs[10] = mkVec(2, 16'h3C00, 16'h0C00, 0, 0, 0, 0, 16'h3C00, 0, 0, 2);
        vecs[11] = mkVec(2, 16'h0600, 16'h8400, 0, 0, 0, 0, 16'h0000, 0, 0, 2);
        vecs[12] = mkVec(2, 16'h3C00, 16'hC200, 0, 0, 0, 0, 16'hC000, 0, 0, 2);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        in_flags  = 5'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_data", {16'd0, out_data}, 32'd0);
        checkOutput("reset_out_count", {29'd0, out_count}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);

        foreach (vecs[k]) begin
            runVector(vecs[k]);
            releaseOutput();
        end

        // Result held for five cycles with out_ready low; words offered
        // meanwhile must not be accepted.
        runVector(mkVec(2, 16'h3C00, 16'h4000, 0, 0, 0, 0, 16'h4200, 0, 0, 2));
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 16'h3C00;
            @(negedge clk);
            checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_out_data", {16'd0, out_data}, 32'h4200);
            checkOutput("hold_out_count", {29'd0, out_count}, 32'd2);
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        releaseOutput();
        runVector(mkVec(1, 16'h3C00, 0, 0, 0, 5'h10, 0, 16'h3C00, 5'h10, 0, 1));
        releaseOutput();

        // Reset mid-vector discards the partial sum.
        applyStimulus(16'h3C00, 5'd0, 1'b0);
        applyStimulus(16'h3C00, 5'd0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midreset_out_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        checkOutput("postreset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("postreset_out_valid", {31'd0, out_valid}, 32'd0);
        runVector(mkVec(1, 16'h4200, 0, 0, 0, 0, 0, 16'h4200, 0, 0, 1));
        releaseOutput();

        // Nine zero words against a 3-bit counter: count sticks at 7.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(16'h0000, 5'd0, (i == 8));
            if (i == 8)
                sb.push_back('{data: 16'h0000, flags: 5'd0, ovf: 1'b0, count: 3'd7});
        end
        collectOutput();
        releaseOutput();

        checkOutput("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
